// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp behind a 16-byte bus window,
// with a registered machine timer interrupt level.
`timescale 1ns/1ps
module mtimer #(
  parameter logic [31:0] BASE_ADDR    = 32'hA000_0000,
  parameter logic [31:0] ADDR_MASK    = 32'hFFFF_FFF0,
  parameter int unsigned PRESCALE     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        timer_irq_o
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_count;
  logic            tick;
  logic [63:0]     mtime;
  logic [63:0]     mtimecmp;
  logic [63:0]     mtime_base;
  logic [63:0]     mtime_next;
  logic [63:0]     mtimecmp_next;
  logic            hit;
  logic            wr_hit;
  logic            rd_hit;
  logic [1:0]      word_sel;
  logic [31:0]     rd_word;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] result;
    result = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) result[8*i +: 8] = new_val[8*i +: 8];
    end
    return result;
  endfunction

  assign hit      = req_i && ((addr_i & ADDR_MASK) == BASE_ADDR);
  assign wr_hit   = hit && we_i;
  assign rd_hit   = hit && !we_i;
  assign word_sel = addr_i[3:2];
  assign tick     = (ps_count == PS_LAST);

  // Increment first (full 64-bit carry), then let written bytes override it.
  always_comb begin
    mtime_base    = tick ? (mtime + 64'd1) : mtime;
    mtime_next    = mtime_base;
    mtimecmp_next = mtimecmp;
    if (wr_hit) begin
      case (word_sel)
        2'd0: mtime_next[31:0]     = merge_bytes(mtime_base[31:0], wdata_i, be_i);
        2'd1: mtime_next[63:32]    = merge_bytes(mtime_base[63:32], wdata_i, be_i);
        2'd2: mtimecmp_next[31:0]  = merge_bytes(mtimecmp[31:0], wdata_i, be_i);
        default: mtimecmp_next[63:32] = merge_bytes(mtimecmp[63:32], wdata_i, be_i);
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    case (word_sel)
      2'd0: rd_word = mtime[31:0];
      2'd1: rd_word = mtime[63:32];
      2'd2: rd_word = mtimecmp[31:0];
      default: rd_word = mtimecmp[63:32];
    endcase
  end

  // Read data and the interrupt level both come from pre-edge register values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ps_count    <= '0;
      mtime       <= '0;
      mtimecmp    <= MTIMECMP_RST;
      rvalid_o    <= 1'b0;
      rdata_o     <= '0;
      timer_irq_o <= 1'b0;
    end else begin
      ps_count    <= tick ? '0 : ps_count + 1'b1;
      mtime       <= mtime_next;
      mtimecmp    <= mtimecmp_next;
      rvalid_o    <= rd_hit;
      if (rd_hit) rdata_o <= rd_word;
      timer_irq_o <= (mtime >= mtimecmp);
    end
  end

endmodule
